// File: rtl/clk_div_prog_pkg.sv
// Shared constants for the programmable divider and the stopwatch timebase it feeds.
package clk_div_prog_pkg;

    localparam int DEF_CNT_W   = 20;
    localparam int DEF_DIV_MIN = 2;

    // 26.2144 MHz reference down to the 100 Hz stopwatch tick.
    localparam int SW_REF_HZ  = 26_214_400;
    localparam int SW_TICK_HZ = 100;
    localparam int SW_DIV     = SW_REF_HZ / SW_TICK_HZ;

    localparam int DEF_DIV_DEFAULT = SW_DIV;

endpackage

// File: rtl/div_shadow_reg.sv
// Divisor request handshake: holds the last valid request until the divider
// reaches a period boundary (apply), then acks it; rejects too-small divisors.
module div_shadow_reg
    import clk_div_prog_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIV_MIN = DEF_DIV_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             apply,
    output logic [CNT_W-1:0] shadow,
    output logic             pending,
    output logic             div_ack,
    output logic             div_err
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             div_ack_q, div_ack_d;
    logic             div_err_q, div_err_d;
    logic             bad_req, good_req;

    assign bad_req  = div_load && (div_in < CNT_W'(DIV_MIN));
    assign good_req = div_load && !bad_req;

    // apply consumes the pre-edge pending state; a request on the same edge
    // survives as the next pending one.
    always_comb begin
        shadow_d  = good_req ? div_in : shadow_q;
        pending_d = (pending_q && !apply) || good_req;
        div_ack_d = apply && pending_q;
        div_err_d = bad_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            div_ack_q <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_ack_q <= div_ack_d;
            div_err_q <= div_err_d;
        end
    end

    assign shadow  = shadow_q;
    assign pending = pending_q;
    assign div_ack = div_ack_q;
    assign div_err = div_err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: registered square wave plus one tick per period,
// with divisor changes deferred to period boundaries so no runt periods appear.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DIV_DEFAULT = DEF_DIV_DEFAULT,
    parameter int DIV_MIN     = DEF_DIV_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             wrap, apply;

    // >= rather than == so a counter left above the last slot still wraps.
    assign wrap  = en && (cnt_q >= cur_div_q - CNT_W'(1));
    assign apply = wrap || clr;

    div_shadow_reg #(
        .CNT_W   (CNT_W),
        .DIV_MIN (DIV_MIN)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_load (div_load),
        .div_in   (div_in),
        .apply    (apply),
        .shadow   (shadow),
        .pending  (pending),
        .div_ack  (div_ack),
        .div_err  (div_err)
    );

    always_comb begin
        cur_div_d = (apply && pending) ? shadow : cur_div_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (clr) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (en) begin
            cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
            // Phase uses the divisor in effect after this edge.
            clk_out_d = (cnt_d >= (cur_div_d >> 1));
            tick_d    = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cur_div_q <= CNT_W'(DIV_DEFAULT);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign cur_div = cur_div_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule
